// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings and helpers for the RV32M multiply/divide sequencer.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
// Optional feature macro used by the sequencer: MULDIV_EARLY_OUT_EN.
package muldiv_sequencer_pkg;

    // funct3 encodings of the M extension
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam int MUL_CYCLES_DEF = 2;
    localparam int DIV_ITERS      = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // One latched M-extension request
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    // Divide by zero or signed overflow: the answer is known without iterating
    function automatic logic div_early(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        return op[2] && ((b == 32'd0) ||
                         (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    // RISC-V defined result for the early-out cases (op[1] selects remainder)
    function automatic logic [31:0] div_corner(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        return op[1] ? 32'd0 : 32'h8000_0000;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore.
// Latency: combinational.
// Backpressure: none; the sequencer decides when to register the outputs.
module muldiv_div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quot,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quot
);

    // 33-bit partial remainder: the stored remainder stays below the divisor,
    // so after a successful subtract it always fits back into 32 bits.
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_borrow;

    assign w_shift  = {i_rem, i_quot[31]};
    assign w_diff   = w_shift - {1'b0, i_divisor};
    assign w_borrow = w_diff[32];
    assign o_rem    = w_borrow ? w_shift[31:0] : w_diff[31:0];
    assign o_quot   = {i_quot[30:0], ~w_borrow};

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide controller with start/busy/done handshake (optional MULDIV_EARLY_OUT_EN).
// Latency: multiply MUL_CYCLES+1, divide 34, early-out divide 1 cycle after accept.
// Backpressure: busy stalls the core; start only sampled in IDLE/DONE, abort cancels.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs1_val,
    input  logic [31:0] i_rs2_val,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    state_e      r_state;
    req_t        r_req;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_dvsr;
    logic        r_done;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_sgn_in;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_early;
    logic [31:0] w_early_res;
    logic        w_a_sx;
    logic        w_b_sx;
    logic [63:0] w_prod;
    logic [31:0] w_mul_res;
    logic        w_sgn;
    logic        w_q_neg;
    logic        w_r_neg;
    logic [31:0] w_fix_res;
    logic [31:0] w_step_rem;
    logic [31:0] w_step_quot;

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start && !i_abort;
    assign o_busy   = w_accept || (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
    assign o_done   = r_done;
    assign o_result = r_result;

    // Divider operand magnitudes at accept time (DIV/REM are signed: op[0]==0)
    assign w_sgn_in = !i_op[0];
    assign w_a_mag  = (w_sgn_in && i_rs1_val[31]) ? -i_rs1_val : i_rs1_val;
    assign w_b_mag  = (w_sgn_in && i_rs2_val[31]) ? -i_rs2_val : i_rs2_val;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early     = div_early(i_op, i_rs1_val, i_rs2_val);
    assign w_early_res = div_corner(i_op, i_rs1_val, i_rs2_val);
`else
    assign w_early     = 1'b0;
    assign w_early_res = 32'd0;
`endif

    // Multiplier: the 64-bit wrap-around product of the sign-extended operands
    // equals the low 64 bits of the 33x33 signed product.
    assign w_a_sx    = ((r_req.op == OP_MULH) || (r_req.op == OP_MULHSU)) && r_req.a[31];
    assign w_b_sx    = (r_req.op == OP_MULH) && r_req.b[31];
    assign w_prod    = {{32{w_a_sx}}, r_req.a} * {{32{w_b_sx}}, r_req.b};
    assign w_mul_res = (r_req.op == OP_MUL) ? w_prod[31:0] : w_prod[63:32];

    // Sign fix-up; x/0 keeps an all-ones quotient and the full dividend as remainder
    assign w_sgn     = !r_req.op[0];
    assign w_q_neg   = w_sgn && (r_req.a[31] ^ r_req.b[31]) && (r_req.b != 32'd0);
    assign w_r_neg   = w_sgn && r_req.a[31];
    assign w_fix_res = r_req.op[1] ? (w_r_neg ? -r_rem : r_rem)
                                   : (w_q_neg ? -r_quot : r_quot);

    muldiv_div_step u_div_step (
        .i_rem     (r_rem),
        .i_quot    (r_quot),
        .i_divisor (r_dvsr),
        .o_rem     (w_step_rem),
        .o_quot    (w_step_quot)
    );

    // Sequencer FSM: accept, iterate, fix up, pulse done with the registered result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_req    <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_dvsr   <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (i_abort) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_req <= '{op: i_op, a: i_rs1_val, b: i_rs2_val};
                        if (!i_op[2]) begin
                            r_state <= S_MUL;
                            r_cnt   <= 5'(MUL_CYCLES - 1);
                        end else if (w_early) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_early_res;
                        end else begin
                            r_state <= S_DIV;
                            r_cnt   <= 5'(DIV_ITERS - 1);
                            r_rem   <= '0;
                            r_quot  <= w_a_mag;
                            r_dvsr  <= w_b_mag;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (r_cnt == 5'd0) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_mul_res;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_step_rem;
                    r_quot <= w_step_quot;
                    if (r_cnt == 5'd0)
                        r_state <= S_FIX;
                    else
                        r_cnt <= r_cnt - 5'd1;
                end
                S_FIX: begin
                    r_state  <= S_DONE;
                    r_done   <= 1'b1;
                    r_result <= w_fix_res;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a result scoreboard.
// Latency: checks done cycle against MUL_CYCLES+1 / 34 / early-out 1.
// Backpressure: checks busy window, abort and reset behaviour.
module tb_muldiv_sequencer;

    localparam int MC      = 2;
    localparam int LAT_MUL = MC + 1;
    localparam int LAT_DIV = 34;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_EO  = 1;
`else
    localparam int LAT_EO  = 34;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];
    logic [31:0] last_res;

    muldiv_sequencer #(.MUL_CYCLES(MC)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_op      (op),
        .i_rs1_val (rs1),
        .i_rs2_val (rs2),
        .i_abort   (abort),
        .o_busy    (busy),
        .o_done    (done),
        .o_result  (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycle: done must not repeat and the result must be held
    task automatic idle(input string tag);
        tick();
        #1;
        chk({tag, " idle done"}, done, 1'b0);
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " idle hold"}, result, last_res);
    endtask

    // Issue one op in the current cycle (cycle 0) and follow it to done
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int   cyc;
        int   drops;
        logic got;
        logic [31:0] want;
        sb.push_back(exp);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        #1;
        chk({tag, " busy0"}, busy, 1'b1);
        cyc   = 0;
        drops = 0;
        got   = 1'b0;
        while (!got && cyc < 100) begin
            tick();
            start = 1'b0;
            cyc++;
            #1;
            if (done === 1'b1) got = 1'b1;
            else if (busy !== 1'b1) drops++;
        end
        want = sb.pop_front();
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " busy window"}, drops, 0);
        if (got) begin
            chk({tag, " result"}, result, want);
            chk({tag, " busy at done"}, busy, 1'b0);
            last_res = want;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        op    = 3'd0;
        rs1   = '0;
        rs2   = '0;
        last_res = 32'd0;
        tick();
        tick();
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 32'd0);
        rst = 1'b0;
        idle("post-reset");

        // Multiply
        run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_MUL);
        idle("MUL");
        run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL);
        idle("MULHU");
        run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LAT_MUL);
        idle("MULHSU");
        run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_MUL);
        idle("MULH");

        // Divide
        run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_DIV);
        idle("DIV");
        run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_DIV);
        idle("REM");
        run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, LAT_DIV);
        run_op("REMU 100/7 b2b", 3'd7, 32'd100, 32'd7, 32'd2, LAT_DIV);
        idle("REMU");

        // Corner cases
        run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_EO);
        idle("DIVU0");
        run_op("REM -5/0", 3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_EO);
        idle("REM0");
        run_op("DIV -5/0", 3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, LAT_EO);
        idle("DIV0");
        run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_EO);
        idle("DIVOVF");
        run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_EO);
        idle("REMOVF");

        // Abort at cycle 10 of a divide
        start = 1'b1;
        op    = 3'd4;
        rs1   = 32'd1234;
        rs2   = 32'd3;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        abort = 1'b1;
        #1;
        chk("abort busy during", busy, 1'b1);
        tick();
        abort = 1'b0;
        #1;
        chk("abort busy after", busy, 1'b0);
        chk("abort result", result, last_res);
        begin
            int dones = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (done !== 1'b0) dones++;
            end
            chk("abort no done", dones, 0);
        end
        run_op("MUL after abort", 3'd0, 32'd6, 32'd9, 32'd54, LAT_MUL);
        idle("after abort");

        // Abort wins over start in the same cycle
        start = 1'b1;
        abort = 1'b1;
        op    = 3'd0;
        rs1   = 32'd3;
        rs2   = 32'd3;
        #1;
        chk("abort+start busy", busy, 1'b0);
        tick();
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("abort+start ignored", busy, 1'b0);
        idle("abort+start");

        // Reset in the middle of a divide
        start = 1'b1;
        op    = 3'd5;
        rs1   = 32'd999;
        rs2   = 32'd10;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst result", result, 32'd0);
        last_res = 32'd0;
        tick();
        rst = 1'b0;
        idle("after rst");

        // Back-to-back multiplies: second start lands in the DONE cycle
        run_op("MUL b2b first", 3'd0, 32'd11, 32'd13, 32'd143, LAT_MUL);
        run_op("MUL b2b second", 3'd0, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, LAT_MUL);
        idle("b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
